// File: rtl/vga_pkg.sv
// Purpose: shared VGA timing constants, colour types and the colour expansion helper.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the default 640x480@60 timing, the derived sync positions and totals,
// and the RGB332 -> RGB444 expansion used by the output stage.
package vga_pkg;

    localparam int CLK_DIV = 4;   // system clocks per pixel

    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;   // 800

    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;   // 525

    // Sync pulse spans, inclusive at both ends.
    localparam int H_SYNC_START = H_VIS + H_FP;               // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;  // 751
    localparam int V_SYNC_START = V_VIS + V_FP;               // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;  // 491

    localparam int CNT_W = 10;    // h_cnt / v_cnt width

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // RGB332 to RGB444: replicate the top bits into the new LSBs so that
    // full-scale input maps to full-scale output.
    function automatic rgb444_t expand_rgb332(input logic [7:0] c);
        rgb444_t o;
        o.r = {c[7:5], c[7]};
        o.g = {c[4:2], c[4]};
        o.b = {c[1:0], c[1:0]};
        return o;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Purpose: pixel-rate divider plus horizontal/vertical raster counters (stage 0).
// Latency: all outputs are combinational from the counter state.
// Backpressure: none; free-running raster.
//
// Ports: clk, rst_n (async, active-low); pix_en (one clk per pixel),
// pix_valid/pix_x/pix_y (visible-region position), hs0/vs0 (active-low
// stage-0 sync), frame_tick (pulse entering vertical blanking).
module vga_timing #(
    parameter int CLK_DIV = 4,
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic       pix_valid,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       hs0,
    output logic       vs0,
    output logic       frame_tick
);
    import vga_pkg::*;

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_B  = H_VIS + H_FP;
    localparam int HS_E  = HS_B + H_SYNC - 1;
    localparam int VS_B  = V_VIS + V_FP;
    localparam int VS_E  = VS_B + V_SYNC - 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;

    assign pix_en = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign h_last = (h_cnt == CNT_W'(H_TOT - 1));
    assign v_last = (v_cnt == CNT_W'(V_TOT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (pix_en) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // v_cnt only moves on the pixel where the line wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_en) begin
            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    assign pix_valid  = (h_cnt < CNT_W'(H_VIS)) && (v_cnt < CNT_W'(V_VIS));
    assign pix_x      = pix_valid ? h_cnt : '0;
    assign pix_y      = pix_valid ? v_cnt[8:0] : '0;
    assign hs0        = !((h_cnt >= CNT_W'(HS_B)) && (h_cnt <= CNT_W'(HS_E)));
    assign vs0        = !((v_cnt >= CNT_W'(VS_B)) && (v_cnt <= CNT_W'(VS_E)));
    // High for the clk whose edge moves the raster from the last visible
    // line into vertical blanking.
    assign frame_tick = pix_en && h_last && (v_cnt == CNT_W'(V_VIS - 1));

endmodule

// File: rtl/vga_ctrl.sv
// Purpose: VGA controller top: raster timing plus registered sync and colour outputs.
// Latency: hsync/vsync/vga_* lag the counters (pix_x/pix_y) by one pixel period.
// Backpressure: none; rgb_in must be valid on every pix_en cycle.
//
// Ports: clk, rst_n (async, active-low); rgb_in RGB332 from the picture stage;
// pix_x/pix_y/pix_valid raster position to the picture stage; frame_tick to
// game logic; hsync/vsync active-low; vga_r/g/b 4-bit DAC drive.
module vga_ctrl #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [8:0] pix_y,
    output logic       pix_valid,
    output logic       frame_tick,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b
);
    import vga_pkg::*;

    logic    pix_en;
    logic    hs0;
    logic    vs0;
    rgb444_t col_q;

    vga_timing #(
        .CLK_DIV (CLK_DIV),
        .H_VIS   (H_VIS),
        .H_FP    (H_FP),
        .H_SYNC  (H_SYNC),
        .H_BP    (H_BP),
        .V_VIS   (V_VIS),
        .V_FP    (V_FP),
        .V_SYNC  (V_SYNC),
        .V_BP    (V_BP)
    ) u_timing (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hs0        (hs0),
        .vs0        (vs0),
        .frame_tick (frame_tick)
    );

    // Sync and colour share one register stage so they stay aligned with
    // each other; rgb_in is only looked at on pix_en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            col_q <= '0;
        end else if (pix_en) begin
            hsync <= hs0;
            vsync <= vs0;
            col_q <= pix_valid ? expand_rgb332(rgb_in) : '0;
        end
    end

    assign vga_r = col_q.r;
    assign vga_g = col_q.g;
    assign vga_b = col_q.b;

endmodule

// File: tb/tb_vga_ctrl.sv
// Purpose: self-checking bench for vga_ctrl on a scaled-down raster.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_ctrl;

    // Small raster so several whole frames fit in a short run.
    localparam int D  = 4;
    localparam int HV = 16, HF = 2, HS = 3, HB = 3;
    localparam int VV = 8,  VF = 1, VS = 2, VB = 2;
    localparam int HT = HV + HF + HS + HB;   // 24 pixels per line
    localparam int VT = VV + VF + VS + VB;   // 13 lines per frame

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rgb_in = 8'h00;
    logic [9:0] pix_x;
    logic [8:0] pix_y;
    logic       pix_valid, frame_tick, hsync, vsync;
    logic [3:0] vga_r, vga_g, vga_b;

    vga_ctrl #(
        .CLK_DIV(D), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
        .frame_tick(frame_tick), .hsync(hsync), .vsync(vsync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // k = clock edges since reset released; the raster position is k / D pixels.
    int         k = 0;
    logic [7:0] pending = 8'h00;   // colour driven during the current pix_en clk
    logic [7:0] exp_rgb = 8'h00;   // colour the DUT should have captured last
    bit         const_mode = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k <= 0;
        end else begin
            if (k % D == D - 1) exp_rgb <= pending;
            k <= k + 1;
        end
    end

    // Real pixel data only in pix_en clks; junk everywhere else.
    initial begin
        forever begin
            @(negedge clk);
            if (k % D == D - 1) begin
                pending = const_mode ? 8'b111_011_00 : 8'($urandom);
                rgb_in  = pending;
            end else begin
                rgb_in  = 8'($urandom);
            end
        end
    end

    function automatic int exp_r(input logic [7:0] c);
        int r3 = int'(c[7:5]);
        return r3 * 2 + r3 / 4;
    endfunction
    function automatic int exp_g(input logic [7:0] c);
        int g3 = int'(c[4:2]);
        return g3 * 2 + g3 / 4;
    endfunction
    function automatic int exp_b(input logic [7:0] c);
        return int'(c[1:0]) * 5;
    endfunction

    // Edge-spacing measurements, in clocks, since the latest reset.
    int  t_now;
    int  hs_fall = -1, hs_per = -1, hs_low = -1;
    int  vs_fall = -1, vs_per = -1, vs_low = -1;
    int  ft_fall = -1, ft_per = -1;
    bit  p_hs = 1'b1, p_vs = 1'b1, p_ft = 1'b0;

    always @(negedge clk) begin : cmp
        int  p, h, v, q, hq, vq;
        bit  vis, visq, e_hs, e_vs, e_ft;
        int  e_r, e_g, e_b;
        p    = k / D;
        h    = p % HT;
        v    = (p / HT) % VT;
        vis  = (h < HV) && (v < VV);
        e_ft = (k % D == D - 1) && (h == HT - 1) && (v == VV - 1);
        e_hs = 1'b1; e_vs = 1'b1; e_r = 0; e_g = 0; e_b = 0;
        if (p > 0) begin
            q    = p - 1;
            hq   = q % HT;
            vq   = (q / HT) % VT;
            visq = (hq < HV) && (vq < VV);
            e_hs = !(hq >= HV + HF && hq < HV + HF + HS);
            e_vs = !(vq >= VV + VF && vq < VV + VF + VS);
            if (visq) begin
                e_r = exp_r(exp_rgb);
                e_g = exp_g(exp_rgb);
                e_b = exp_b(exp_rgb);
            end
        end
        chk("pix_valid",  32'(pix_valid),  32'(vis));
        chk("pix_x",      32'(pix_x),      vis ? h : 0);
        chk("pix_y",      32'(pix_y),      vis ? v : 0);
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
        chk("hsync",      32'(hsync),      32'(e_hs));
        chk("vsync",      32'(vsync),      32'(e_vs));
        chk("vga_r",      32'(vga_r),      e_r);
        chk("vga_g",      32'(vga_g),      e_g);
        chk("vga_b",      32'(vga_b),      e_b);

        t_now = int'($time / 10);
        if (!rst_n) begin
            hs_fall = -1; hs_per = -1; hs_low = -1;
            vs_fall = -1; vs_per = -1; vs_low = -1;
            ft_fall = -1; ft_per = -1;
            p_hs = 1'b1; p_vs = 1'b1; p_ft = 1'b0;
        end else begin
            if (p_hs && !hsync) begin
                if (hs_fall >= 0) hs_per = t_now - hs_fall;
                hs_fall = t_now;
            end
            if (!p_hs && hsync && hs_fall >= 0) hs_low = t_now - hs_fall;
            if (p_vs && !vsync) begin
                if (vs_fall >= 0) vs_per = t_now - vs_fall;
                vs_fall = t_now;
            end
            if (!p_vs && vsync && vs_fall >= 0) vs_low = t_now - vs_fall;
            if (p_ft && !frame_tick) begin
                if (ft_fall >= 0) ft_per = t_now - ft_fall;
                ft_fall = t_now;
            end
            p_hs = hsync; p_vs = vsync; p_ft = frame_tick;
        end
    end

    initial begin : main
        bit found;
        // Held in reset: literal reset values.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_rgb",   {20'h0, vga_r, vga_g, vga_b}, 0);
        chk("rst_pix",   {13'h0, pix_x, pix_y}, 0);
        chk("rst_ftick", 32'(frame_tick), 0);

        // Release, random colours, run into the frame until h=10, v=5.
        @(negedge clk);
        rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if ((k / D) % HT == 10 && (k / D) / HT == 5) found = 1'b1;
        end
        chk("wait_mid_frame", 32'(found), 1);
        chk("mid_pix_x", 32'(pix_x), 10);
        chk("mid_pix_y", 32'(pix_y), 5);

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async_pix_x", 32'(pix_x), 0);
        chk("async_pix_y", 32'(pix_y), 0);
        chk("async_hsync", 32'(hsync), 1);
        chk("async_vsync", 32'(vsync), 1);
        chk("async_rgb",   {20'h0, vga_r, vga_g, vga_b}, 0);
        chk("async_ftick", 32'(frame_tick), 0);
        const_mode = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // k=3: still pixel 0, nothing registered yet.
        repeat (3) @(negedge clk);
        chk("pre_pix_en_x",   32'(pix_x), 0);
        chk("pre_pix_en_rgb", {20'h0, vga_r, vga_g, vga_b}, 0);
        // k=4: first pix_en has happened; pixel (0,0) colour is out.
        @(negedge clk);
        chk("first_pix_x", 32'(pix_x), 1);
        chk("first_r",     32'(vga_r), 32'hF);
        chk("first_g",     32'(vga_g), 32'h6);
        chk("first_b",     32'(vga_b), 32'h0);
        chk("first_hsync", 32'(hsync), 1);
        chk("first_vsync", 32'(vsync), 1);
        // k=68: output stage shows column 16, first blanking pixel.
        repeat (64) @(negedge clk);
        chk("blank_valid", 32'(pix_valid), 0);
        chk("blank_rgb",   {20'h0, vga_r, vga_g, vga_b}, 0);
        chk("vis_r_before_blank", 32'(k), 68);
        const_mode = 1'b0;

        // Three and a half frames for edge spacing.
        repeat (4400) @(negedge clk);
        chk("hsync_low_clks",  32'(hs_low), 12);    // 3 px * 4
        chk("hsync_period",    32'(hs_per), 96);    // 24 px * 4
        chk("vsync_low_clks",  32'(vs_low), 192);   // 2 lines * 24 px * 4
        chk("vsync_period",    32'(vs_per), 1248);  // 13 * 24 * 4
        chk("ftick_period",    32'(ft_per), 1248);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_ctrl.md
VGA_CTRL -- requirements
Module: vga_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel; 100 MHz clk gives a 25 MHz pixel rate.
REQ-002 Parameters H_VIS/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels, total 800.
REQ-003 Parameters V_VIS/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines, total 525.
REQ-004 clk  input  1: system clock; all logic is on the rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 rgb_in  input  8: pixel colour from the picture stage, R[7:5] G[4:2] B[1:0].
REQ-007 pix_x  output  10: current visible column, 0..639, sent to the picture stage.
REQ-008 pix_y  output  9: current visible row, 0..479, sent to the picture stage.
REQ-009 pix_valid  output  1: high while the counters are inside the visible region.
REQ-010 frame_tick  output  1: one-clk pulse at the start of vertical blanking, used by game logic.
REQ-011 hsync, vsync  output  1 each: sync outputs, active-low.
REQ-012 vga_r, vga_g, vga_b  output  4 each: DAC colour outputs.

Function
REQ-013 Clock divider: counts 0..CLK_DIV-1 and wraps; pix_en is high for one clk when the divider equals CLK_DIV-1.
REQ-014 h_cnt (10 b): increments on pix_en; wraps 799->0.
REQ-015 v_cnt (10 b): increments on pix_en only when h_cnt wraps; v_cnt wraps 524->0 at the same time as h_cnt wraps.
REQ-016 Visible region: pix_valid = (h_cnt<640)&&(v_cnt<480), combinational from the counters.
REQ-017 pix_x = h_cnt when pix_valid, else 0.
REQ-018 pix_y = v_cnt[8:0] when pix_valid, else 0.
REQ-019 Stage 0 sync timing: hs0 is low for h_cnt in 656..751; vs0 is low for v_cnt in 490..491.
REQ-020 Output register, updated on pix_en: hsync<=hs0, vsync<=vs0, colour<=expand(rgb_in) if pix_valid else 0.
REQ-021 Because of REQ-020, colour and sync both lag the counters by exactly one pixel period and stay mutually aligned.
REQ-022 Colour expansion:
- vga_r = {R[2:0], R[2]}
- vga_g = {G[2:0], G[2]}
- vga_b = {B[1:0], B[1:0]}
REQ-023 frame_tick pulses for one clk on the pix_en where h_cnt 799->0 and v_cnt 479->480.
REQ-024 rgb_in is sampled only on pix_en; changes between pix_en pulses have no effect on the outputs.
REQ-025 Counter arithmetic is unsigned; no intermediate value exceeds 10 bits.

Reset
REQ-026 While rst_n is low, all of the following are cleared:
- divider, h_cnt, v_cnt = 0
- hsync = vsync = 1
- vga_r/g/b = 0
- frame_tick = 0
REQ-027 Reset asserted mid-frame takes effect immediately, without waiting for a clk edge.
REQ-028 After rst_n deasserts, the first pix_en occurs on the CLK_DIV-th clk edge, and the frame restarts at h_cnt = v_cnt = 0.

Structure
REQ-029 The timing constants (REQ-002/003), the sync start/end positions and the totals live in the shared package vga_pkg; the picture stage reuses H_VIS and V_VIS from it.
REQ-030 One sub-module, vga_timing, contains the divider, h_cnt, v_cnt and the stage-0 signals (pix_en, pix_valid, hs0, vs0).
REQ-031 vga_ctrl contains the output register and the colour expansion.

Verification
REQ-032 Reset check: with rst_n low, hsync=vsync=1, vga_r/g/b=0 and pix_x=pix_y=0; after release, the first pix_en occurs 4 clk later.
REQ-033 Horizontal timing: hsync low pulse is 96 pixels = 384 clk long, and hsync falling edges are 800 pixels = 3200 clk apart.
REQ-034 Vertical timing and frame_tick:
- vsync is low for 2 lines = 1600 pixels
- vsync falling edges are 420000 pixels = 1680000 clk apart
- frame_tick falling edges are also 1680000 clk apart
REQ-035 Colour: constant rgb_in = 8'b111_011_00 gives r=4'hF, g=4'h6, b=4'h0 in the visible region, and 0 during blanking.
REQ-036 Alignment: the first non-zero colour appears one pixel period after pix_x=0, pix_y=0, with hsync=vsync=1 at that point.
REQ-037 Reset mid-frame: pulse rst_n at h_cnt=300, v_cnt=200; all outputs reach reset values immediately, and the frame restarts at 0,0.
